multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that sequences the shared ALU, register file, PC and memories of the RV32 core.
//  Per instruction: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].

---
 rtl/multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 core: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and resolves branches; hung memory handshakes trap to ERR.
module multicycle_ctrl #(
   parameter int WAIT_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       less,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic [1:0] PCSel,
   output logic [1:0] ALUOp,
   output logic       ALUSrc,
   output logic       Jump,
   output logic [2:0] BranchType,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] MemtoReg,
   output logic       instr_done,
   output logic       err,
   output logic [2:0] state
);

   localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_BAD
   } iclass_t;

   state_t        state_q;
   iclass_t       iclass;
   logic [CW-1:0] wait_cnt;
   logic          err_q;
   logic          waiting;
   logic          timeout;
   logic          br_taken;

   always_comb begin
      unique case (opcode)
         7'b0110011: iclass = C_R;
         7'b0010011: iclass = C_I;
         7'b0000011: iclass = C_LW;
         7'b0100011: iclass = C_SW;
         7'b1100011: iclass = C_BR;
         7'b1101111: iclass = C_JAL;
         7'b1100111: iclass = C_JALR;
         default:    iclass = C_BAD;
      endcase
   end

   // The ALU already evaluated the condition; funct3 only picks which flag holds it.
   always_comb begin
      unique case (funct3)
         3'b010, 3'b011: br_taken = 1'b0;
         default:        br_taken = funct3[2] ? less : zero;
      endcase
   end

   assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                    ((state_q == S_MEM)   && !dmem_ready);
   assign timeout = (WAIT_MAX != 0) && waiting && (wait_cnt == CW'(WAIT_MAX));

   // NOTE: sequential state uses non-blocking assignments only, so the default
   // clear of wait_cnt below is safely overridden by the later increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= '0;
         unique case (state_q)
            S_FETCH: begin
               if (imem_ready) begin
                  state_q <= S_DECODE;
               end else if (timeout) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               if (iclass == C_BAD) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               unique case (iclass)
                  C_R, C_I, C_JAL, C_JALR: state_q <= S_WB;
                  C_LW, C_SW:              state_q <= S_MEM;
                  C_BR:                    state_q <= S_FETCH;
                  default: begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  state_q <= (iclass == C_LW) ? S_WB : S_FETCH;
               end else if (timeout) begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB:  state_q <= S_FETCH;
            S_ERR: state_q <= S_ERR;
            default: begin
               state_q <= S_ERR;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: every output gets a default first, so no latch is inferred, and the
   // rst gate drops memory requests immediately rather than at the next edge.
   always_comb begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSel      = 2'd0;
      ALUOp      = 2'b00;
      ALUSrc     = 1'b0;
      Jump       = 1'b0;
      BranchType = 3'd0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      MemtoReg   = 2'd0;
      instr_done = 1'b0;
      if (!rst) begin
         unique case (state_q)
            S_FETCH: IRWrite = imem_ready;
            S_EXEC: begin
               unique case (iclass)
                  C_R: ALUOp = 2'b10;
                  C_I, C_LW, C_SW: ALUSrc = 1'b1;
                  C_JALR: begin
                     Jump   = 1'b1;
                     ALUSrc = 1'b1;
                  end
                  C_BR: begin
                     ALUOp      = 2'b01;
                     BranchType = funct3;
                     PCWrite    = 1'b1;
                     instr_done = 1'b1;
                     PCSel      = br_taken ? 2'd1 : 2'd0;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (iclass == C_LW) begin
                  MemRead = 1'b1;
               end else if (iclass == C_SW) begin
                  MemWrite = 1'b1;
                  if (dmem_ready) begin
                     PCWrite    = 1'b1;
                     instr_done = 1'b1;
                  end
               end
            end
            S_WB: begin
               RegWrite   = 1'b1;
               PCWrite    = 1'b1;
               instr_done = 1'b1;
               unique case (iclass)
                  C_LW:    MemtoReg = 2'd1;
                  C_JAL: begin
                     MemtoReg = 2'd2;
                     PCSel    = 2'd1;
                  end
                  C_JALR: begin
                     MemtoReg = 2'd2;
                     PCSel    = 2'd2;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign err   = err_q;
   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each cycle's expected state/outputs are
// queued as stimulus is applied and popped when the DUT outputs are sampled.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = OP_R;
   logic [2:0] funct3 = 3'd0;
   logic       zero = 1'b0, less = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
   logic       IRWrite, PCWrite, ALUSrc, Jump, MemRead, MemWrite, RegWrite, instr_done, err;
   logic [1:0] PCSel, ALUOp, MemtoReg;
   logic [2:0] BranchType, state;

   multicycle_ctrl #(.WAIT_MAX(8)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .less(less),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSel(PCSel), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Jump(Jump), .BranchType(BranchType),
      .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .instr_done(instr_done), .err(err), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       irw;
      logic       pcw;
      logic [1:0] pcsel;
      logic [1:0] aluop;
      logic       alusrc;
      logic       jump;
      logic [2:0] bt;
      logic       mr;
      logic       mw;
      logic       rw;
      logic [1:0] m2r;
      logic       done;
      logic       err;
   } snap_t;

   snap_t exp_q[$];
   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    cyc_no = 0;
   int    last_done_cyc = -1;

   function automatic snap_t s(input logic [2:0] st);
      snap_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   function automatic snap_t observe();
      snap_t r;
      r.st = state; r.irw = IRWrite; r.pcw = PCWrite; r.pcsel = PCSel; r.aluop = ALUOp;
      r.alusrc = ALUSrc; r.jump = Jump; r.bt = BranchType; r.mr = MemRead; r.mw = MemWrite;
      r.rw = RegWrite; r.m2r = MemtoReg; r.done = instr_done; r.err = err;
      return r;
   endfunction

   task automatic compare(input string nm);
      snap_t e, a;
      total_cnt++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         a = observe();
         if (a !== e)
            $display("FAIL %s: got %b expected %b (st,irw,pcw,pcsel,aluop,alusrc,jump,bt,mr,mw,rw,m2r,done,err)",
                     nm, a, e);
         else
            pass_cnt++;
      end
   endtask

   task automatic cyc(input string nm, input snap_t e, input logic imr, input logic dmr,
                      input logic z, input logic l);
      imem_ready = imr; dmem_ready = dmr; zero = z; less = l;
      exp_q.push_back(e);
      @(negedge clk);
      cyc_no++;
      if (instr_done === 1'b1) last_done_cyc = cyc_no;
      compare(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string nm);
      @(posedge clk); #1;
      rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
      exp_q.push_back(s(F));
      @(negedge clk);
      compare(nm);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      opcode = OP_SW;
      do_reset("reset outputs");
   endtask

   task automatic test_add();
      snap_t e;
      opcode = OP_R; funct3 = 3'd0;
      e = s(F); e.irw = 1; cyc("add fetch", e, 1, 0, 0, 0);
      cyc("add decode", s(D), 1, 0, 0, 0);
      e = s(E); e.aluop = 2'b10; cyc("add exec", e, 1, 0, 0, 0);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; cyc("add wb", e, 1, 0, 0, 0);
   endtask

   task automatic test_lw_wait();
      snap_t e;
      int start;
      opcode = OP_LW; funct3 = 3'b010;
      start = cyc_no;
      e = s(F); e.irw = 1; cyc("lw fetch", e, 1, 0, 0, 0);
      cyc("lw decode", s(D), 1, 0, 0, 0);
      e = s(E); e.alusrc = 1; cyc("lw exec", e, 1, 0, 0, 0);
      e = s(M); e.mr = 1;
      for (int i = 0; i < 3; i++) cyc("lw mem wait", e, 1, 0, 0, 0);
      cyc("lw mem ready", e, 1, 1, 0, 0);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; e.m2r = 2'd1; cyc("lw wb", e, 1, 0, 0, 0);
      total_cnt++;
      if (last_done_cyc - start !== 8)
         $display("FAIL lw latency: done on cycle %0d, expected cycle 8", last_done_cyc - start);
      else
         pass_cnt++;
   endtask

   task automatic branch(input string nm, input logic [2:0] f3, input logic z, input logic l,
                         input logic taken);
      snap_t e;
      opcode = OP_BR; funct3 = f3;
      e = s(F); e.irw = 1; cyc({nm, " fetch"}, e, 1, 0, z, l);
      cyc({nm, " decode"}, s(D), 1, 0, z, l);
      e = s(E); e.aluop = 2'b01; e.bt = f3; e.pcw = 1; e.done = 1;
      e.pcsel = taken ? 2'd1 : 2'd0;
      cyc({nm, " exec"}, e, 1, 0, z, l);
   endtask

   task automatic test_branch();
      branch("beq taken", 3'b000, 1, 0, 1);
      branch("bltu not taken", 3'b110, 1, 0, 0);
      branch("bge taken", 3'b101, 0, 1, 1);
      branch("f3 010 not taken", 3'b010, 1, 1, 0);
   endtask

   task automatic test_jumps();
      snap_t e;
      opcode = OP_JALR; funct3 = 3'd0;
      e = s(F); e.irw = 1; cyc("jalr fetch", e, 1, 0, 0, 0);
      cyc("jalr decode", s(D), 1, 0, 0, 0);
      e = s(E); e.jump = 1; e.alusrc = 1; cyc("jalr exec", e, 1, 0, 0, 0);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; e.m2r = 2'd2; e.pcsel = 2'd2;
      cyc("jalr wb", e, 1, 0, 0, 0);
      opcode = OP_JAL;
      e = s(F); e.irw = 1; cyc("jal fetch", e, 1, 0, 0, 0);
      cyc("jal decode", s(D), 1, 0, 0, 0);
      cyc("jal exec", s(E), 1, 0, 1, 1);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; e.m2r = 2'd2; e.pcsel = 2'd1;
      cyc("jal wb", e, 1, 0, 0, 0);
   endtask

   task automatic test_sw();
      snap_t e;
      opcode = OP_SW; funct3 = 3'b010;
      e = s(F); e.irw = 1; cyc("sw fetch", e, 1, 0, 0, 0);
      cyc("sw decode", s(D), 1, 0, 0, 0);
      e = s(E); e.alusrc = 1; cyc("sw exec", e, 1, 0, 0, 0);
      e = s(M); e.mw = 1; cyc("sw mem wait", e, 1, 0, 0, 0);
      e.pcw = 1; e.done = 1; cyc("sw mem ready", e, 1, 1, 0, 0);
   endtask

   task automatic test_rst_mid_mem();
      snap_t e;
      opcode = OP_SW;
      e = s(F); e.irw = 1; cyc("rsw fetch", e, 1, 0, 0, 0);
      cyc("rsw decode", s(D), 1, 0, 0, 0);
      e = s(E); e.alusrc = 1; cyc("rsw exec", e, 1, 0, 0, 0);
      e = s(M); e.mw = 1; cyc("rsw mem", e, 1, 0, 0, 0);
      #2 rst = 1'b1;
      #1 exp_q.push_back(s(F));
      compare("rst mid mem");
      @(posedge clk); #1;
      rst = 1'b0;
      opcode = OP_I;
      e = s(F); e.irw = 1; cyc("post rst fetch", e, 1, 1, 0, 0);
      cyc("addi decode", s(D), 1, 1, 0, 0);
      e = s(E); e.alusrc = 1; cyc("addi exec", e, 1, 1, 0, 0);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; cyc("addi wb", e, 1, 1, 0, 0);
   endtask

   task automatic test_wait_boundary();
      snap_t e;
      opcode = OP_R;
      for (int i = 0; i < 8; i++) cyc("fetch stall", s(F), 0, 0, 0, 0);
      e = s(F); e.irw = 1; cyc("fetch ready at limit", e, 1, 0, 0, 0);
      cyc("late decode", s(D), 1, 0, 0, 0);
      e = s(E); e.aluop = 2'b10; cyc("late exec", e, 1, 0, 0, 0);
      e = s(W); e.rw = 1; e.pcw = 1; e.done = 1; cyc("late wb", e, 1, 0, 0, 0);
   endtask

   task automatic test_timeout();
      snap_t e;
      for (int i = 0; i < 9; i++) cyc("timeout fetch", s(F), 0, 0, 0, 0);
      e = s(X); e.err = 1;
      cyc("timeout err", e, 1, 1, 1, 1);
      cyc("timeout err held", e, 1, 1, 1, 1);
      do_reset("timeout reset");
   endtask

   task automatic test_illegal();
      snap_t e;
      opcode = OP_LUI;
      e = s(F); e.irw = 1; cyc("illegal fetch", e, 1, 0, 0, 0);
      cyc("illegal decode", s(D), 1, 0, 0, 0);
      e = s(X); e.err = 1;
      cyc("illegal err", e, 1, 1, 0, 0);
      opcode = OP_R;
      cyc("illegal err held", e, 1, 1, 0, 0);
      do_reset("illegal reset");
      e = s(F); e.irw = 1; cyc("after reset fetch", e, 1, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jumps();
      test_sw();
      test_rst_mid_mem();
      test_wait_boundary();
      test_timeout();
      test_illegal();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
